mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Main control FSM for the multi-cycle MIPS datapath. It shares one memory and one ALU across the fetch, decode, execute, memory and write-back steps. It reads the opcode from the instruction register and drives every datapath enable and mux select as a Moore function of its state. It also waits on a memory-ready handshake and counts retired instructions for the benches.

## Interface
- No parameters; opcode and state encodings live in the shared package.
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- opcode  input  6  IR[31:26]; sampled only in DECODE
- mem_ready  input  1  memory completes the current access this cycle
- zero  input  1  ALU zero flag; used only in BRANCH
- pc_write, pc_write_cond, ior_d, mem_read, mem_write, mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst  output  1 each  datapath enables and selects
- pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_op  output  2  00 add, 01 sub, 10 use funct
- alu_src_b  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- illegal  output  1  one-cycle pulse when an unsupported opcode is decoded
- instr_count  output  32  number of retired instructions

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP.
- Reset puts the FSM in IDLE. IDLE drives every output to 0, then goes to FETCH on the next edge.
- FETCH: mem_read=1, ir_write=1, alu_src_b=01, pc_write=1, pc_source=00, alu_op=00.
  - If mem_ready=0, stay in FETCH and force ir_write and pc_write to 0. Other FETCH outputs are unchanged.
  - If mem_ready=1, go to DECODE.
- DECODE: alu_src_b=11 (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDI_EXEC
  - any other opcode → FETCH, with illegal=1 for that DECODE cycle
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Goes to MEM_READ for lw, MEM_WRITE for sw. The opcode is latched in DECODE.
- MEM_READ: mem_read=1, ior_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
- MEM_WRITE: mem_write=1, ior_d=1. Holds until mem_ready, then retires.
- R_EXEC: alu_src_a=1, alu_op=10. R_WB: reg_write=1, reg_dst=1.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. ADDI_WB: reg_write=1, reg_dst=0.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01.
- JUMP: pc_write=1, pc_source=10.
- Retire states: MEM_WB, MEM_WRITE (mem_ready=1), R_WB, ADDI_WB, BRANCH, JUMP. Each goes to FETCH and adds 1 to instr_count. instr_count wraps from FFFFFFFF to 0.
- An illegal opcode does not increment instr_count.
- Outputs not listed for a state are 0.

## Timing
- State is registered. Outputs are combinational from state plus mem_ready, so they are valid the same cycle.
- Reset values: state=IDLE, all control outputs 0, illegal=0, instr_count=0. Assertion is asynchronous.
- Reset asserted mid-instruction aborts it: no further write enables and no count increment. Release leads to IDLE, then FETCH.
- Cycles per instruction with mem_ready held 1, counted from FETCH entry to the next FETCH:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - illegal: 2
- A cycle with mem_ready=0 adds exactly one cycle in FETCH, MEM_READ or MEM_WRITE.
- mem_ready is ignored in every other state.
- The opcode latch is updated only in DECODE, so a changing IR later in the instruction does not affect sequencing.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - the state enum (4-bit encoding)
  - alu_op, alu_src_b and pc_source encodings
- One sub-module, mips_ctrl_decode: purely combinational state-to-outputs decode.
- The top holds the state register, opcode latch, next-state logic and instr_count.

## Test plan
- Reset then release, mem_ready=1, R-type opcode: IDLE→FETCH→DECODE→R_EXEC→R_WB→FETCH. reg_write=1 and reg_dst=1 only in R_WB. instr_count=1.
- lw with mem_ready low for 2 cycles in MEM_READ: 7 cycles from FETCH entry to next FETCH. reg_write and mem_to_reg asserted exactly one cycle.
- beq with zero=1, then zero=0: both instructions take 3 cycles. pc_write_cond=1, pc_source=01 and alu_op=01 in BRANCH. instr_count increases by 2.
- Opcode 111111: illegal pulses for 1 cycle in DECODE, the next state is FETCH, instr_count is unchanged and no write enable is asserted.
- Force instr_count to FFFFFFFF, then execute j: instr_count=00000000, with pc_source=10 and pc_write=1 in JUMP.
- Assert rst_n in MEM_WRITE with mem_ready=0: mem_write drops immediately. After release, one IDLE cycle with all outputs 0, then FETCH. instr_count=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states,
// datapath select codes and the bundled control-word type.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_R_EXEC,
        S_R_WB,
        S_ADDI_EXEC,
        S_ADDI_WB,
        S_BRANCH,
        S_JUMP
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-control-word decode; mem_ready only gates the
// FETCH-stage write enables.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_ADDI_WB: ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: state register, opcode
// latch, next-state sequencing and retired-instruction counter.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        ior_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        ir_write,
    output logic        alu_src_a,
    output logic        reg_write,
    output logic        reg_dst,
    output logic [1:0]  pc_source,
    output logic [1:0]  alu_op,
    output logic [1:0]  alu_src_b,
    output logic        illegal,
    output logic [31:0] instr_count
);

    state_t     state;
    state_t     state_next;
    logic [5:0] op_q;
    logic       retire;
    ctrl_t      ctrl;

    // Branch resolution happens in the datapath (pc_write_cond AND zero).
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= '0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE)
                op_q <= opcode;
            if (retire)
                instr_count <= instr_count + 32'd1;
        end
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_next = S_R_EXEC;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EXEC;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_next = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_R_EXEC:    state_next = S_R_WB;
            S_ADDI_EXEC: state_next = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign illegal = (state == S_DECODE) && !is_legal_op(opcode);

    mips_ctrl_decode u_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ior_d         = ctrl.ior_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign ir_write      = ctrl.ir_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign alu_src_b     = ctrl.alu_src_b;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class
// cycle by cycle and checks state, control word, illegal and instr_count.
module tb_mips_multicycle_control;
    import mips_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        zero;
    logic        pc_write, pc_write_cond, ior_d, mem_read, mem_write;
    logic        mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst;
    logic [1:0]  pc_source, alu_op, alu_src_b;
    logic        illegal;
    logic [31:0] instr_count;
    logic [15:0] obs;

    int checks = 0;
    int fails  = 0;

    // {pc_write, pc_write_cond, ior_d, mem_read, mem_write, mem_to_reg,
    //  ir_write, alu_src_a, reg_write, reg_dst, pc_source, alu_op, alu_src_b}
    localparam logic [15:0] C_ZERO      = 16'h0000;
    localparam logic [15:0] C_FETCH     = 16'h9201;
    localparam logic [15:0] C_FETCH_NR  = 16'h1001;
    localparam logic [15:0] C_DECODE    = 16'h0003;
    localparam logic [15:0] C_MEM_ADDR  = 16'h0102;
    localparam logic [15:0] C_MEM_READ  = 16'h3000;
    localparam logic [15:0] C_MEM_WB    = 16'h0480;
    localparam logic [15:0] C_MEM_WRITE = 16'h2800;
    localparam logic [15:0] C_R_EXEC    = 16'h0108;
    localparam logic [15:0] C_R_WB      = 16'h00C0;
    localparam logic [15:0] C_ADDI_EXEC = 16'h0102;
    localparam logic [15:0] C_ADDI_WB   = 16'h0080;
    localparam logic [15:0] C_BRANCH    = 16'h4114;
    localparam logic [15:0] C_JUMP      = 16'h8020;

    assign obs = {pc_write, pc_write_cond, ior_d, mem_read, mem_write, mem_to_reg,
                  ir_write, alu_src_a, reg_write, reg_dst, pc_source, alu_op, alu_src_b};

    mips_multicycle_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .zero          (zero),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ior_d         (ior_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .ir_write      (ir_write),
        .alu_src_a     (alu_src_a),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_b     (alu_src_b),
        .illegal       (illegal),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_now(input string tag, input state_t es, input logic [15:0] ec);
        chk({tag, " state"}, 32'(dut.state), 32'(es));
        chk({tag, " ctrl"}, 32'(obs), 32'(ec));
    endtask

    task automatic step(input string tag, input state_t es, input logic [15:0] ec);
        @(posedge clk);
        #1;
        chk_now(tag, es, ec);
    endtask

    initial begin
        rst_n     = 1'b1;
        opcode    = OP_RTYPE;
        mem_ready = 1'b1;
        zero      = 1'b0;
        #2 rst_n  = 1'b0;
        #1;
        chk_now("reset", S_IDLE, C_ZERO);
        chk("reset illegal", 32'(illegal), 32'd0);
        chk("reset count", instr_count, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk_now("idle after release", S_IDLE, C_ZERO);

        // R-type: 4 cycles FETCH to FETCH
        step("r fetch", S_FETCH, C_FETCH);
        step("r decode", S_DECODE, C_DECODE);
        chk("r decode illegal", 32'(illegal), 32'd0);
        step("r exec", S_R_EXEC, C_R_EXEC);
        step("r wb", S_R_WB, C_R_WB);
        step("r next fetch", S_FETCH, C_FETCH);
        chk("r count", instr_count, 32'd1);

        // lw with two not-ready MEM_READ cycles; IR changes after DECODE
        opcode = OP_LW;
        step("lw decode", S_DECODE, C_DECODE);
        step("lw addr", S_MEM_ADDR, C_MEM_ADDR);
        opcode    = OP_SW;
        mem_ready = 1'b0;
        step("lw read0", S_MEM_READ, C_MEM_READ);
        step("lw read1", S_MEM_READ, C_MEM_READ);
        step("lw read2", S_MEM_READ, C_MEM_READ);
        mem_ready = 1'b1;
        step("lw wb", S_MEM_WB, C_MEM_WB);
        step("lw next fetch", S_FETCH, C_FETCH);
        chk("lw count", instr_count, 32'd2);

        // sw with one not-ready MEM_WRITE cycle
        opcode = OP_SW;
        step("sw decode", S_DECODE, C_DECODE);
        step("sw addr", S_MEM_ADDR, C_MEM_ADDR);
        mem_ready = 1'b0;
        step("sw write0", S_MEM_WRITE, C_MEM_WRITE);
        chk("sw stalled count", instr_count, 32'd2);
        step("sw write1", S_MEM_WRITE, C_MEM_WRITE);
        mem_ready = 1'b1;
        step("sw next fetch", S_FETCH, C_FETCH);
        chk("sw count", instr_count, 32'd3);

        // FETCH stall then addi
        mem_ready = 1'b0;
        #1;
        chk_now("fetch stall", S_FETCH, C_FETCH_NR);
        step("fetch held", S_FETCH, C_FETCH_NR);
        mem_ready = 1'b1;
        opcode    = OP_ADDI;
        #1;
        chk_now("fetch ready", S_FETCH, C_FETCH);
        step("addi decode", S_DECODE, C_DECODE);
        step("addi exec", S_ADDI_EXEC, C_ADDI_EXEC);
        step("addi wb", S_ADDI_WB, C_ADDI_WB);
        step("addi next fetch", S_FETCH, C_FETCH);
        chk("addi count", instr_count, 32'd4);

        // beq taken, then not taken: 3 cycles each
        opcode = OP_BEQ;
        zero   = 1'b1;
        step("beq1 decode", S_DECODE, C_DECODE);
        step("beq1 branch", S_BRANCH, C_BRANCH);
        step("beq1 next fetch", S_FETCH, C_FETCH);
        zero = 1'b0;
        step("beq2 decode", S_DECODE, C_DECODE);
        step("beq2 branch", S_BRANCH, C_BRANCH);
        step("beq2 next fetch", S_FETCH, C_FETCH);
        chk("beq count", instr_count, 32'd6);

        // illegal opcode
        opcode = 6'b111111;
        step("ill decode", S_DECODE, C_DECODE);
        chk("ill pulse", 32'(illegal), 32'd1);
        step("ill next fetch", S_FETCH, C_FETCH);
        chk("ill pulse end", 32'(illegal), 32'd0);
        chk("ill count", instr_count, 32'd6);

        // j with counter at all-ones wraps to zero
        force dut.instr_count = 32'hFFFF_FFFF;
        opcode = OP_J;
        step("j decode", S_DECODE, C_DECODE);
        release dut.instr_count;
        #1;
        chk("j preset count", instr_count, 32'hFFFF_FFFF);
        step("j jump", S_JUMP, C_JUMP);
        step("j next fetch", S_FETCH, C_FETCH);
        chk("j wrap count", instr_count, 32'd0);

        opcode = OP_ADDI;
        step("addi2 decode", S_DECODE, C_DECODE);
        step("addi2 exec", S_ADDI_EXEC, C_ADDI_EXEC);
        step("addi2 wb", S_ADDI_WB, C_ADDI_WB);
        step("addi2 next fetch", S_FETCH, C_FETCH);
        chk("addi2 count", instr_count, 32'd1);

        // reset asserted during a stalled sw
        opcode = OP_SW;
        step("sw2 decode", S_DECODE, C_DECODE);
        mem_ready = 1'b0;
        step("sw2 addr", S_MEM_ADDR, C_MEM_ADDR);
        step("sw2 write", S_MEM_WRITE, C_MEM_WRITE);
        rst_n = 1'b0;
        #1;
        chk_now("abort reset", S_IDLE, C_ZERO);
        chk("abort count", instr_count, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk_now("abort idle", S_IDLE, C_ZERO);
        step("abort fetch", S_FETCH, C_FETCH);
        chk("abort final count", instr_count, 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
